norm_seq_ctrl: RTL and testbench

//  Sequential normalization controller for the 64-bit mantissa path. Accepts {mantissa, exponent},

---
 rtl/norm_seq_ctrl_pkg.sv | 40 ++++
 rtl/norm_seq_ctrl_if.sv | 35 +++
 rtl/norm_seq_ctrl_lzc.sv | 24 ++
 rtl/norm_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_norm_seq_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/norm_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// norm_pkg : shared types and constants for the sequential normalization
// controller (norm_seq_ctrl).
//   normState_t  : controller FSM states IDLE/COUNT/SHIFT/HOLD
//   MANT_W       : mantissa width (64)
//   LZ_W         : leading-zero count / shift amount width (8)
//   DEF_EXP_W    : default exponent width used by the result record
//   normResult_t : one normalized result {mant, exp, zero, uflow}
//   stepOf()     : per-cycle shift amount, min(remaining, maxStep)
// -----------------------------------------------------------------------------
package norm_pkg;

  localparam int MANT_W    = 64;
  localparam int LZ_W      = 8;
  localparam int DEF_EXP_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } normState_t;

  typedef struct packed {
    logic [MANT_W-1:0]    mant;
    logic [DEF_EXP_W-1:0] exp;
    logic                 zero;
    logic                 uflow;
  } normResult_t;

  // Shift applied in one SHIFT cycle: never more than what is still owed.
  function automatic logic [LZ_W-1:0] stepOf(input logic [LZ_W-1:0] remaining,
                                             input int unsigned      maxStep);
    if (32'(remaining) < maxStep) begin
      return remaining;
    end
    return LZ_W'(maxStep);
  endfunction

endpackage

// File: rtl/norm_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// norm_seq_ctrl_if : valid/ready bus between the ALU result stage (master),
// the normalization controller (slave) and the packer.
//   in_valid/in_ready/in_mant/in_exp          : operand handshake
//   out_valid/out_ready/out_mant/out_exp/
//   out_zero/out_uflow                        : result handshake
//   busy                                      : controller not idle
// Parameter EXP_W must match the controller's EXP_W.
// -----------------------------------------------------------------------------
interface norm_seq_ctrl_if #(parameter int EXP_W = 11);
  import norm_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] in_mant;
  logic [EXP_W-1:0]  in_exp;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic              out_zero;
  logic              out_uflow;
  logic              busy;

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, busy
  );

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, busy
  );

endinterface

// File: rtl/norm_seq_ctrl_lzc.sv
// -----------------------------------------------------------------------------
// norm_seq_ctrl_lzc : combinational 64-bit leading-zero counter.
//   mant : input word
//   lz   : number of zeros above the most significant one; 0 for an all-zero
//          input (the caller must detect zero separately)
// -----------------------------------------------------------------------------
module norm_seq_ctrl_lzc
  import norm_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  output logic [LZ_W-1:0]   lz
);

  // Scan upward; the highest set bit is written last and therefore wins.
  always_comb begin
    lz = '0;
    for (int i = 0; i < MANT_W; i++) begin
      if (mant[i]) begin
        lz = LZ_W'(MANT_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/norm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// norm_seq_ctrl : sequential normalization controller for the 64-bit mantissa
// path. Accepts {mantissa, exponent}, counts leading zeros, shifts left at most
// SHIFT_STEP bits per cycle until bit 63 is set, lowers the exponent by the
// applied shift and flags zero / exponent underflow.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : norm_seq_ctrl_if.slave (operand and result handshakes, busy)
// Parameters : EXP_W (exponent width), SHIFT_STEP (power of 2, 1..64)
// Build option: NORM_DENORM_EN -- when defined, an exponent too small for the
//   full shift limits the shift to the exponent (gradual underflow, denormal
//   result, no uflow flag); otherwise the mantissa is always fully normalized
//   and the exponent clamps at 0 with uflow raised.
// -----------------------------------------------------------------------------
module norm_seq_ctrl
  import norm_pkg::*;
#(
  parameter int EXP_W      = 11,
  parameter int SHIFT_STEP = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  norm_seq_ctrl_if.slave bus
);

  normState_t        stateReg, stateNext;
  logic [MANT_W-1:0] mantReg;
  logic [EXP_W-1:0]  expReg;
  logic              zeroReg;
  logic              uflowReg;
  logic [LZ_W-1:0]   remReg;
  logic [LZ_W-1:0]   lzReg;
  logic              lzDoneReg;

  logic [LZ_W-1:0]   lzcOut;
  logic              mantZero;
  logic              expUnder;
  logic [LZ_W-1:0]   eff;
  logic [EXP_W-1:0]  expAfter;
  logic              uflowAfter;
  logic [LZ_W-1:0]   step;
  logic [LZ_W-1:0]   remAfter;

  norm_seq_ctrl_lzc uLzc (
    .mant (mantReg),
    .lz   (lzcOut)
  );

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  assign mantZero = (mantReg == '0);
  assign expUnder = (32'(lzReg) > 32'(expReg));
  assign step     = stepOf(remReg, SHIFT_STEP);
  assign remAfter = remReg - step;

  always_comb begin
    eff        = lzReg;
    expAfter   = expReg - EXP_W'(lzReg);
    uflowAfter = 1'b0;
    if (expUnder) begin
      expAfter = '0;
`ifdef NORM_DENORM_EN
      // Shift only as far as the exponent allows; expReg < lzReg fits LZ_W.
      eff        = LZ_W'(expReg);
      uflowAfter = 1'b0;
`else
      eff        = lzReg;
      uflowAfter = 1'b1;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // COUNT takes two cycles: the first registers the counter result, the
  // second acts on it.
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE: begin
        if (bus.in_valid) begin
          stateNext = COUNT;
        end
      end
      COUNT: begin
        if (lzDoneReg) begin
          if (mantZero || (eff == '0)) begin
            stateNext = HOLD;
          end else begin
            stateNext = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (remAfter == '0) begin
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = (stateReg == IDLE);
    bus.out_valid = (stateReg == HOLD);
    bus.busy      = (stateReg != IDLE);
  end

  assign bus.out_mant  = mantReg;
  assign bus.out_exp   = expReg;
  assign bus.out_zero  = zeroReg;
  assign bus.out_uflow = uflowReg;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mantReg   <= '0;
      expReg    <= '0;
      zeroReg   <= 1'b0;
      uflowReg  <= 1'b0;
      remReg    <= '0;
      lzReg     <= '0;
      lzDoneReg <= 1'b0;
    end else begin
      unique case (stateReg)
        IDLE: begin
          if (bus.in_valid) begin
            mantReg   <= bus.in_mant;
            expReg    <= bus.in_exp;
            zeroReg   <= 1'b0;
            uflowReg  <= 1'b0;
            remReg    <= '0;
            lzDoneReg <= 1'b0;
          end
        end
        COUNT: begin
          if (!lzDoneReg) begin
            lzReg     <= lzcOut;
            lzDoneReg <= 1'b1;
          end else if (mantZero) begin
            // Counter reports 0 for zero input; flag it here instead.
            zeroReg <= 1'b1;
            mantReg <= '0;
            expReg  <= '0;
          end else begin
            expReg   <= expAfter;
            uflowReg <= uflowAfter;
            remReg   <= eff;
          end
        end
        SHIFT: begin
          mantReg <= mantReg << step;
          remReg  <= remAfter;
        end
        HOLD: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_norm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_norm_seq_ctrl : self-checking bench for norm_seq_ctrl (directed cases plus
// randomized operands checked against a behavioural model). Honors the
// NORM_DENORM_EN build option in its model.
// -----------------------------------------------------------------------------
module tb_norm_seq_ctrl;
  import norm_pkg::*;

  localparam int EXP_W      = 11;
  localparam int SHIFT_STEP = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  norm_seq_ctrl_if #(.EXP_W(EXP_W)) bus ();

  norm_seq_ctrl #(.EXP_W(EXP_W), .SHIFT_STEP(SHIFT_STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Behavioural model: normalize by repeated doubling, then apply the
  // exponent rules and derive the cycle count from the shift amount.
  task automatic model(input logic [63:0] m, input logic [EXP_W-1:0] e,
                       output normResult_t res, output int lat);
    int          lz;
    int          effAmt;
    logic [63:0] t;
    res = '0;
    if (m == 64'd0) begin
      res.zero = 1'b1;
      lat      = 2;
      return;
    end
    lz = 0;
    t  = m;
    while (t[63] == 1'b0) begin
      t  = t * 2;
      lz = lz + 1;
    end
    if (lz > int'(e)) begin
`ifdef NORM_DENORM_EN
      effAmt    = int'(e);
      res.uflow = 1'b0;
`else
      effAmt    = lz;
      res.uflow = 1'b1;
`endif
      res.exp = '0;
    end else begin
      effAmt  = lz;
      res.exp = e - EXP_W'(lz);
    end
    res.mant = m << effAmt;
    lat      = 2 + (effAmt + SHIFT_STEP - 1) / SHIFT_STEP;
  endtask

  // One complete transaction: offer, wait for result, hold, release.
  task automatic runOp(input string name, input logic [63:0] m,
                       input logic [EXP_W-1:0] e, input int holdCyc);
    normResult_t want;
    int          wantLat;
    int          lat;
    logic [63:0] heldMant;
    model(m, e, want, wantLat);
    @(negedge clk);
    check({name, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_mant  = m;
    bus.in_exp   = e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_mant  = {$urandom, $urandom};
    bus.in_exp   = EXP_W'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, ".latency"}, 64'(lat), 64'(wantLat));
    check({name, ".mant"}, bus.out_mant, want.mant);
    check({name, ".exp"}, 64'(bus.out_exp), 64'(want.exp));
    check({name, ".zero"}, 64'(bus.out_zero), 64'(want.zero));
    check({name, ".uflow"}, 64'(bus.out_uflow), 64'(want.uflow));
    heldMant = bus.out_mant;
    for (int i = 0; i < holdCyc; i++) begin
      bus.in_valid = 1'b1;
      bus.in_mant  = {$urandom, $urandom};
      @(posedge clk);
      #1;
      check({name, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({name, ".hold_mant"}, bus.out_mant, heldMant);
      check({name, ".hold_exp"}, 64'(bus.out_exp), 64'(want.exp));
      check({name, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, ".release_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, ".release_busy"}, 64'(bus.busy), 64'd0);
    $display("txn %s mant=%h exp=%0d -> mant=%h exp=%0d zero=%0b uflow=%0b lat=%0d",
             name, m, e, bus.out_mant, bus.out_exp, bus.out_zero, bus.out_uflow, lat);
  endtask

  initial begin
    logic [63:0] rm;
    logic [EXP_W-1:0] re;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.out_mant", bus.out_mant, 64'd0);
    check("rst.out_exp", 64'(bus.out_exp), 64'd0);
    check("rst.flags", 64'({bus.out_zero, bus.out_uflow}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);

    // Directed cases
    runOp("normalized",  64'h8000_0000_0000_0000, 11'd100, 0);
    runOp("lz40",        64'h0000_0000_0080_0000, 11'd100, 1);
    runOp("zero",        64'h0,                   11'd55,  0);
    runOp("lz63_exp10",  64'h1,                   11'd10,  0);
    runOp("hold4",       64'h0000_0000_0080_0000, 11'd100, 4);
    runOp("lz_eq_exp",   64'h0000_0000_0080_0000, 11'd40,  0);
    runOp("lz_gt_exp",   64'h0000_0000_0080_0000, 11'd39,  0);
    runOp("lz32",        64'h0000_0000_8000_0000, 11'd2047, 0);
    runOp("lz1_exp0",    64'h4000_0000_0000_0000, 11'd0,   0);

    // Reset in the middle of SHIFT aborts the operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mant  = 64'h0000_0000_0080_0000;
    bus.in_exp   = 11'd100;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort.busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort.out_mant", bus.out_mant, 64'd0);
    check("abort.out_exp", 64'(bus.out_exp), 64'd0);
    check("abort.flags", 64'({bus.out_zero, bus.out_uflow}), 64'd0);
    check("abort.out_valid", 64'(bus.out_valid), 64'd0);
    check("abort.busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("after_abort", 64'h0000_0000_0080_0000, 11'd100, 0);

    // Randomized operands
    for (int n = 0; n < 30; n++) begin
      rm = {$urandom, $urandom};
      rm = rm >> $urandom_range(0, 64);
      if ($urandom_range(0, 1) == 0) begin
        re = EXP_W'($urandom_range(0, 70));
      end else begin
        re = EXP_W'($urandom);
      end
      runOp($sformatf("rand%0d", n), rm, re, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
